sprite_loader: RTL and testbench



---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_loader_if.sv | 15 +
 rtl/sprite_addr_gen.sv | 54 +++++
 rtl/sprite_loader.sv | 125 ++++++++++++
 tb/tb_sprite_loader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite loader and sprite renderer.
//   ld_state_e : loader state machine states
//   idx_w()    : counter/index width helper, never narrower than 1 bit
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UNPACK,
    WAIT_SWAP
  } ld_state_e;

  localparam int unsigned MIN_IDX_W = 1;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : MIN_IDX_W;
  endfunction

endpackage

// File: rtl/sprite_loader_if.sv
// Packed-pixel word stream with a valid/ready handshake.
//   s_valid : source has a word
//   s_ready : sink accepts the word this cycle
//   s_data  : packed pixels, pixel 0 in the LSBs
// master = word source, slave = sprite_loader.
interface sprite_loader_if #(
  parameter int unsigned DW = 16
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sprite_addr_gen.sv
// Pixel position tracker for the sprite loader.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart at row 0, col 0 (load accepted)
//   adv        : one pixel was written this cycle
//   flip       : horizontal mirror for the current load
//   idx        : pixel index within a bank, row*WIDTH + (mirrored) col
//   last_pix   : current position is the final pixel of the sprite
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8,
  parameter int unsigned ADDRW  = $clog2(WIDTH * HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic             flip,
  output logic [ADDRW-1:0] idx,
  output logic             last_pix
);

  localparam int unsigned CW = idx_w(WIDTH);
  localparam int unsigned RW = idx_w(HEIGHT);

  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [ADDRW-1:0] col_m;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clr) begin
      col_q <= '0;
      row_q <= '0;
    end else if (adv) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_q <= '0;
        row_q <= row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  always_comb begin
    col_m    = flip ? (ADDRW'(WIDTH - 1) - ADDRW'(col_q)) : ADDRW'(col_q);
    idx      = ADDRW'(row_q) * ADDRW'(WIDTH) + col_m;
    last_pix = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));
  end

endmodule

// File: rtl/sprite_loader.sv
// Writer side of a double-banked sprite graphic RAM.
// Takes packed pixel words, unpacks one pixel per cycle into the bank the
// renderer is not reading, and swaps banks on a frame pulse once the whole
// sprite has been written.
//   clk, rst_n : clock, synchronous active-low reset
//   frame      : start-of-frame pulse; swaps banks when a load is complete
//   start      : begin a load (only honoured when idle)
//   flip       : horizontal mirror, captured with start
//   s_if       : packed pixel word stream (slave side)
//   wr_en      : RAM write strobe
//   wr_addr    : {bank, pixel index}
//   wr_data    : pixel value
//   rd_bank    : bank the renderer reads
//   busy       : load in progress or awaiting swap
//   done       : one-cycle pulse after a bank swap
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned HEIGHT       = 8,
  parameter int unsigned COLR_BITS    = 4,
  parameter int unsigned PIX_PER_WORD = 4,
  parameter int unsigned ADDRW        = $clog2(WIDTH * HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame,
  input  logic                 start,
  input  logic                 flip,
  sprite_loader_if.slave       s_if,
  output logic                 wr_en,
  output logic [ADDRW:0]       wr_addr,
  output logic [COLR_BITS-1:0] wr_data,
  output logic                 rd_bank,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DW = PIX_PER_WORD * COLR_BITS;
  localparam int unsigned KW = idx_w(PIX_PER_WORD);

  if ((WIDTH * HEIGHT) % PIX_PER_WORD != 0) begin : g_bad_geom
    $error("sprite_loader: WIDTH*HEIGHT must be a multiple of PIX_PER_WORD");
  end

  ld_state_e        state_q, state_d;
  logic [DW-1:0]    sh_q;
  logic [KW-1:0]    k_q;
  logic             flip_q;
  logic             rd_bank_q;
  logic             done_q;
  logic [ADDRW-1:0] idx;
  logic             last_pix;

  sprite_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDRW  (ADDRW)
  ) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      ((state_q == IDLE) && start),
    .adv      (state_q == UNPACK),
    .flip     (flip_q),
    .idx      (idx),
    .last_pix (last_pix)
  );

  always_comb begin
    state_d       = state_q;
    s_if.s_ready  = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      IDLE:      if (start) state_d = LOAD;
      LOAD: begin
        s_if.s_ready = 1'b1;
        if (s_if.s_valid) state_d = UNPACK;
      end
      UNPACK: begin
        wr_en = 1'b1;
        // Word count divides the sprite, so the last pixel is always a last lane.
        if (k_q == KW'(PIX_PER_WORD - 1)) state_d = last_pix ? WAIT_SWAP : LOAD;
      end
      WAIT_SWAP: if (frame) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      k_q       <= '0;
      flip_q    <= 1'b0;
      rd_bank_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) flip_q <= flip;
        LOAD: if (s_if.s_valid) begin
          sh_q <= s_if.s_data;
          k_q  <= '0;
        end
        UNPACK: begin
          sh_q <= sh_q >> COLR_BITS;
          k_q  <= k_q + KW'(1);
        end
        WAIT_SWAP: if (frame) begin
          rd_bank_q <= ~rd_bank_q;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wr_addr = {~rd_bank_q, idx};
  assign wr_data = sh_q[COLR_BITS-1:0];
  assign rd_bank = rd_bank_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_sprite_loader.sv
module tb_sprite_loader;

  localparam int unsigned W    = 8;
  localparam int unsigned H    = 8;
  localparam int unsigned CB   = 4;
  localparam int unsigned PPW  = 4;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned NW   = NPIX / PPW;
  localparam int unsigned AW   = 6;
  localparam int unsigned DW   = PPW * CB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame = 1'b0;
  logic          start = 1'b0;
  logic          flip = 1'b0;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [CB-1:0] wr_data;
  logic          rd_bank;
  logic          busy;
  logic          done;

  sprite_loader_if #(.DW(DW)) s_if ();

  sprite_loader #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .COLR_BITS    (CB),
    .PIX_PER_WORD (PPW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .frame   (frame),
    .start   (start),
    .flip    (flip),
    .s_if    (s_if.slave),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_bank (rd_bank),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned log_edge[$];
  int unsigned log_addr[$];
  int unsigned log_data[$];
  int          rdy_cnt = 0;
  bit          mbank = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge numbering: at a negedge, cyc edges have passed; the next edge is cyc+1.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_edge.push_back(cyc + 1);
      log_addr.push_back(32'(wr_addr));
      log_data.push_back(32'(wr_data));
    end
    if (s_if.s_ready === 1'b1) rdy_cnt++;
    if (s_if.s_ready === 1'b1 || wr_en === 1'b1)
      chk("ready_and_write_overlap", 32'(s_if.s_ready & wr_en), 32'd0);
  end

  task automatic send_word(input logic [DW-1:0] d, input int unsigned gap,
                           output int unsigned acc_edge);
    int n;
    s_if.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    n = 0;
    while (s_if.s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
    acc_edge = cyc + 1;
    @(negedge clk);
    s_if.s_valid = 1'b0;
  endtask

  task automatic run_load(input bit fl, input int unsigned maxgap, input bit pat,
                          input bit poke, input bit late_frame, input int abort_after);
    logic [DW-1:0] words[NW];
    int unsigned   acc[NW];
    int unsigned   st_edge, ready_at, call_c, g, exp_acc, w, j, r, c, n;
    bit            bank;
    bank = ~mbank;
    for (int i = 0; i < int'(NW); i++) begin
      words[i] = DW'($urandom);
      if (pat)
        for (int k = 0; k < int'(PPW); k++)
          words[i][CB*k +: CB] = CB'((i * PPW + k) % 16);
    end
    if (fl) words[0] = 16'h4321;
    log_edge.delete();
    log_addr.delete();
    log_data.delete();

    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    chk("idle_frame_no_swap", 32'(rd_bank), 32'(mbank));
    chk("idle_busy", 32'(busy), 32'd0);

    rdy_cnt = 0;
    start   = 1'b1;
    flip    = fl;
    st_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    flip  = ~fl;
    chk("busy_after_start", 32'(busy), 32'd1);

    for (int i = 0; i < int'(NW); i++) begin
      if (abort_after != 0 && i == abort_after) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(s_if.s_ready), 32'd0);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_bank", 32'(rd_bank), 32'd0);
        mbank = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      ready_at = (i == 0) ? st_edge : acc[i-1] + PPW;
      call_c   = cyc;
      g        = pat ? 0 : $urandom_range(0, maxgap);
      send_word(words[i], g, acc[i]);
      exp_acc  = ((call_c + g > ready_at) ? call_c + g : ready_at) + 1;
      chk($sformatf("accept_edge_w%0d", i), acc[i], exp_acc);
      if (poke && i == 3) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (poke && i == 8) begin
        repeat (PPW) @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        chk("load_frame_no_swap", 32'(rd_bank), 32'(mbank));
      end
    end

    if (late_frame) begin
      repeat (PPW - 1) @(negedge clk);
      chk("late_frame_last_write", 32'(wr_en), 32'd1);
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      chk("late_frame_no_swap", 32'(rd_bank), 32'(mbank));
      chk("late_frame_busy", 32'(busy), 32'd1);
    end else begin
      repeat (PPW) @(negedge clk);
    end

    chk("wait_ready", 32'(s_if.s_ready), 32'd0);
    chk("wait_wr_en", 32'(wr_en), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_rd_bank", 32'(rd_bank), 32'(mbank));
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("wait_start_ignored_busy", 32'(busy), 32'd1);
      chk("wait_start_ignored_wr", 32'(wr_en), 32'd0);
    end

    n = log_addr.size();
    chk("write_count", 32'(n), 32'(NPIX));
    if (n > int'(NPIX)) n = NPIX;
    for (int i = 0; i < int'(n); i++) begin
      w = i / PPW;
      j = i % PPW;
      r = i / W;
      c = i % W;
      chk($sformatf("addr_p%0d", i), log_addr[i],
          32'(bank) * NPIX + r * W + (fl ? (W - 1 - c) : c));
      chk($sformatf("data_p%0d", i), log_data[i], (32'(words[w]) >> (CB * j)) & 32'hF);
      chk($sformatf("edge_p%0d", i), log_edge[i], acc[w] + 1 + j);
    end
    if (pat) chk("ready_cycles", 32'(rdy_cnt), 32'(NW));

    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    mbank = ~mbank;
    chk("swap_rd_bank", 32'(rd_bank), 32'(mbank));
    chk("swap_done", 32'(done), 32'd1);
    chk("swap_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_single_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(s_if.s_ready), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rd_bank", 32'(rd_bank), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_load(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);  // basic back-to-back pattern
    run_load(1'b1, 0, 1'b0, 1'b0, 1'b0, 0);  // mirrored load into bank 0
    run_load(1'b0, 7, 1'b0, 1'b1, 1'b0, 0);  // backpressure + ignored events
    run_load(1'b0, 3, 1'b0, 1'b0, 1'b0, 7);  // reset after 7 words
    run_load(1'b1, 2, 1'b0, 1'b0, 1'b1, 0);  // frame on final pixel

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
